pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
Consumes the iCE40 PLL lock output and generates a clean, synchronously-released core reset in the PLL output clock domain. Holds the core in reset until PLL lock has been stable for a programmable number of cycles. Re-asserts reset on any loss of lock and counts lock-loss events for debug. Sits directly downstream of the PLL primitive (or its simulation model) and upstream of all core logic.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before reset release (>=1)
RESET_HOLD_CYCLES, 16, minimum cycles spent in HOLD after aresetn release or lock loss (>=1)
SYNC_STAGES, 2, flops in the pll_lock synchroniser (>=2)
LOSS_COUNT_WIDTH, 8, width of the lock-loss counter

Ports:
clk  in  1  PLL output clock (PLLOUTCORE); the only clock
aresetn  in  1  asynchronous active-low reset; asserts immediately, released by the board reset
pll_lock  in  1  PLL LOCK; asynchronous to clk
clear_count  in  1  synchronous pulse; clears lock_loss_count
core_sresetn  out  1  synchronous active-low reset for core logic
ready  out  1  high one cycle after core_sresetn goes high; deasserts together with core_sresetn
state  out  2  current FSM state, for debug
lock_loss_count  out  LOSS_COUNT_WIDTH  saturating count of RUN->HOLD transitions

Behaviour:
- All flops async-reset by aresetn low. Reset values: state=HOLD, counter=0, synchroniser flops=0, core_sresetn=0, ready=0, lock_loss_count=0.
- lock_sync = pll_lock after SYNC_STAGES flops. pll_lock high at edge E0 -> lock_sync high after edge E(SYNC_STAGES-1).
- One shared cycle counter, wide enough for max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)-1. Cleared on every state transition.
- FSM states, with encodings: HOLD=0, WAIT_LOCK=1, STABILISE=2, RUN=3.
  - HOLD: counter increments each cycle; when counter==RESET_HOLD_CYCLES-1 -> WAIT_LOCK. Ignores lock_sync, so HOLD always lasts exactly RESET_HOLD_CYCLES cycles.
  - WAIT_LOCK: lock_sync=1 -> STABILISE; otherwise stay.
  - STABILISE: lock_sync=0 -> WAIT_LOCK (counter cleared). Otherwise counter increments; when lock_sync=1 and counter==LOCK_STABLE_CYCLES-1 -> RUN. STABILISE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
  - RUN: lock_sync=0 -> HOLD; otherwise stay.
- core_sresetn is a dedicated flop loaded with (next_state==RUN), so it is glitch-free and changes on the same edge as the state register. It is never decoded combinationally.
- ready is a flop loaded with (core_sresetn & next_state==RUN). It rises one edge after core_sresetn and falls on the same edge as core_sresetn.
- Latency, lock already satisfied case: if the FSM is in WAIT_LOCK and pll_lock rises at E0, core_sresetn goes high after edge E(SYNC_STAGES+LOCK_STABLE_CYCLES).
- Lock loss in RUN: lock_sync=0 sampled at edge E -> state=HOLD, core_sresetn=0, ready=0, all after E.
  - lock_loss_count increments at E and saturates at all-ones.
  - Lock loss in STABILISE or WAIT_LOCK is not counted.
- clear_count: sets lock_loss_count=0 next edge. If clear_count coincides with an increment, the result is 1.
- aresetn assertion mid-operation: all outputs return to reset values immediately (asynchronously). The sequence restarts from HOLD on release.
- Parameter values outside the stated ranges cause an elaboration-time $error.

Decomposition:
- Package pll_reset_pkg: typedef enum logic [1:0] pll_rst_state_t {HOLD, WAIT_LOCK, STABILISE, RUN}.
- Sub-module bit_sync (parameter STAGES; ports clk, aresetn, d, q): reusable single-bit synchroniser. pll_reset_sequencer instantiates one for pll_lock.

Test Plan:
Use LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, SYNC_STAGES=2, LOSS_COUNT_WIDTH=2.
1. pll_lock held 1 from time 0; release aresetn at edge R -> state HOLD for 4 cycles, WAIT_LOCK 1 cycle, STABILISE 8 cycles; core_sresetn high after edge R+13; ready high after R+14.
2. In WAIT_LOCK, pll_lock 0->1 at E0 -> core_sresetn high after E10 exactly, not earlier.
3. In STABILISE at counter=5, pll_lock low for 1 cycle -> state returns to WAIT_LOCK; core_sresetn stays 0; the full 8-cycle STABILISE restarts; lock_loss_count stays 0.
4. In RUN, drop pll_lock 4 separate times -> core_sresetn and ready fall 2 edges after each drop; lock_loss_count 1,2,3,3 (saturated).
5. clear_count pulsed on the same edge as a RUN lock loss with count=3 -> count=1. clear_count pulsed alone -> count=0 next edge.
6. Assert aresetn while in RUN -> core_sresetn=0, ready=0, state=HOLD, count=0 without any clk edge. Release -> sequence restarts as in test 1.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared types for the PLL reset sequencer
// Provides the sequencer FSM state encoding, which is also exported on the debug port.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILISE = 2'd2,
    RUN       = 2'd3
  } pll_rst_state_t;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - single-bit multi-flop synchroniser
// Ports:
//   clk     - destination clock
//   aresetn - asynchronous active-low reset, clears every stage
//   d       - asynchronous input bit
//   q       - input after STAGES flops in the clk domain
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - turns PLL lock into a synchronously released core reset
// Ports:
//   clk             - PLL output clock, the only clock
//   aresetn         - asynchronous active-low board reset
//   pll_lock        - PLL lock, asynchronous to clk
//   clear_count     - synchronous pulse clearing lock_loss_count
//   core_sresetn    - synchronous active-low reset for core logic
//   ready           - high one cycle after core_sresetn rises, falls with it
//   state           - current FSM state (debug)
//   lock_loss_count - saturating count of RUN->HOLD transitions
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int LOSS_COUNT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        pll_lock,
  input  logic                        clear_count,
  output logic                        core_sresetn,
  output logic                        ready,
  output logic [1:0]                  state,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
    $error("pll_reset_sequencer: LOCK_STABLE_CYCLES must be >= 1");
  end
  if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("pll_reset_sequencer: RESET_HOLD_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pll_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (LOSS_COUNT_WIDTH < 1) begin : g_bad_width
    $error("pll_reset_sequencer: LOSS_COUNT_WIDTH must be >= 1");
  end

  // One counter serves both timed states, so it is sized for the longer of the two.
  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic lock_sync;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .aresetn(aresetn),
    .d      (pll_lock),
    .q      (lock_sync)
  );

  pll_rst_state_t              state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        core_sresetn_q, core_sresetn_d;
  logic                        ready_q, ready_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_q, loss_d;
  logic                        loss_inc;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      core_sresetn_q <= 1'b0;
      ready_q        <= 1'b0;
      loss_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      core_sresetn_q <= core_sresetn_d;
      ready_q        <= ready_d;
      loss_q         <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      // HOLD deliberately ignores lock so its length is fixed.
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      WAIT_LOCK: begin
        if (lock_sync) state_d = STABILISE;
      end
      STABILISE: begin
        if (!lock_sync)                state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      RUN: begin
        if (!lock_sync) state_d = HOLD;
      end
    endcase
  end

  // Output flops are loaded from next-state so they switch on the same edge as the state.
  always_comb begin
    core_sresetn_d = (state_d == RUN);
    ready_d        = core_sresetn_q & (state_d == RUN);
  end

  // Only a loss from RUN counts; clear wins over history but not over a coincident loss.
  always_comb begin
    loss_inc = (state_q == RUN) & ~lock_sync;
    loss_d   = loss_q;
    if (clear_count) begin
      loss_d = loss_inc ? LOSS_COUNT_WIDTH'(1) : '0;
    end else if (loss_inc && (loss_q != '1)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  assign core_sresetn    = core_sresetn_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_q;

endmodule
